nn_argmax_classifier: RTL and testbench
=======================================

Name: nn_argmax_classifier

Overview:
- Parametrised successor to the fixed 10-class classification output stage of the NN top level.
- Consumes a stream of signed output-layer scores, one per class, over a valid/ready handshake.
- Tracks the running maximum, then publishes a one-hot classification vector, the class index and a one-cycle done pulse.
- Sits between the final neuron layer and the top-level classification/done ports.

Parameters:
- NUM_CLASSES, 10, number of scores per frame (>=2).
- SCORE_W, 16, signed score width in bits.
- IDX_W, $clog2(NUM_CLASSES), width of the class index.
- MARGIN_THRESH, 0, unsigned low-confidence threshold. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset. 0 = reset asserted.
- score_valid  in  1  score_data is valid this cycle.
- score_ready  out  1  block can accept a score.
- score_data  in  SCORE_W  signed two's-complement score.
- score_last  in  1  marks the final score of a frame.
- classification  out  [0:NUM_CLASSES-1]  one-hot winner. Bit 0 is class 0.
- class_idx  out  IDX_W  winning class index.
- max_score  out  SCORE_W  winning score.
- done  out  1  one-cycle pulse when a new result is published.
- busy  out  1  frame in progress.
- frame_err  out  1  sticky framing error, cleared by the next frame's first beat.

Behaviour:
- Reset (async, reset=0): all outputs 0, except score_ready=0 while in reset. FSM goes to IDLE, counters cleared.
- Transfer: a beat transfers when score_valid && score_ready on a rising clk edge. Data is never dropped or duplicated.
- FSM states:
  - IDLE: score_ready=1, busy=0.
    - First beat loads best=score_data, best_idx=0, cnt=1.
    - Also clears frame_err and goes to ACCUM.
    - If that beat has score_last=1, go straight to DONE with frame_err=1 (short frame).
  - ACCUM: score_ready=1, busy=1.
    - Each beat compares signed score_data > best. On greater, update best and best_idx=cnt.
    - Ties keep the lower index.
    - Then cnt++.
    - Frame ends on score_last=1, or on the beat where cnt==NUM_CLASSES-1 (the NUM_CLASSES-th beat), whichever comes first. Go to DONE.
    - score_last before the NUM_CLASSES-th beat: frame_err=1, result computed over received beats only.
    - NUM_CLASSES-th beat without score_last: frame_err=1, frame still ends.
  - DONE (one cycle): score_ready=0, busy=1, done=1.
    - classification, class_idx and max_score update on entry, using the final comparison including the last beat.
    - Next state is IDLE.
- Latency: done rises on the clk edge after the final beat is accepted. The next frame's first beat is accepted no earlier than 2 cycles after the final beat.
- Result outputs hold their values until the next DONE or reset. classification always has exactly one bit set after the first frame, and all zeros before it.
- Arithmetic: comparison is full-width signed. No saturation is needed; scores are only compared, never summed.
- Reset asserted mid-frame aborts immediately: partial results are discarded, no done pulse is produced, and outputs return to 0.
- score_valid in DONE is ignored. The upstream must hold the beat until ready.

Optional Feature:
- Macro: NN_ARGMAX_MARGIN_EN.
- When defined:
  - Also track the runner-up score. A new maximum demotes the old best to runner-up; otherwise update runner-up if score > runner-up, or score == best at a higher index.
  - Adds output margin (SCORE_W+1 bits, unsigned) = best − runner-up, registered at DONE.
  - Adds output low_conf = (margin <= MARGIN_THRESH), registered at DONE.
  - On a single-beat frame: margin=0, low_conf=1.
  - Both new outputs reset to 0.
- When undefined: neither port exists, and no runner-up logic is built.

Test Plan:
- Basic frame: 10 scores {3,-5,7,2,9,1,0,-8,4,6}, last on beat 10 -> done 1 cycle later; class_idx=4, classification=0000100000, max_score=9, frame_err=0.
- Tie and negatives: scores all -3 except class 2 and class 6 = -1 -> class_idx=2; extreme value test: class 9 = 16'sh8000, others 16'sh8001 -> class_idx=0.
- Framing errors:
  - Short frame: score_last on beat 4 -> done, frame_err=1, result over 4 beats.
  - Missing last: 10 beats with no score_last -> done after beat 10, frame_err=1.
  - The next good frame clears frame_err.
- Back-pressure and bubbles: random score_valid gaps, and score_valid held high through DONE -> score_ready=0 in DONE, no beat lost; two back-to-back frames give two done pulses with correct indices.
- Mid-frame reset: pull reset low after beat 5 -> outputs 0 immediately, no done pulse; the following full frame classifies correctly.
- NN_ARGMAX_MARGIN_EN, MARGIN_THRESH=2: frame best=9, runner-up=8 -> margin=1, low_conf=1; frame best=9, runner-up=4 -> margin=5, low_conf=0.

Source files
------------

// File: rtl/nn_argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : nn_argmax_classifier
//  Description : Streaming argmax over one frame of signed class scores.
//                Accepts NUM_CLASSES scores over valid/ready, tracks the
//                running maximum (ties keep the lower index) and publishes a
//                one-hot vector, class index, winning score and a done pulse.
//                Optional macro NN_ARGMAX_MARGIN_EN adds runner-up tracking
//                with margin / low_conf outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 16,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
`ifdef NN_ARGMAX_MARGIN_EN
  ,
  parameter int unsigned MARGIN_THRESH = 0
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      score_valid,
  output logic                      score_ready,
  input  logic signed [SCORE_W-1:0] score_data,
  input  logic                      score_last,
  output logic [0:NUM_CLASSES-1]    classification,
  output logic [IDX_W-1:0]          class_idx,
  output logic signed [SCORE_W-1:0] max_score,
  output logic                      done,
  output logic                      busy,
  output logic                      frame_err
`ifdef NN_ARGMAX_MARGIN_EN
  ,
  output logic [SCORE_W:0]          margin,
  output logic                      low_conf
`endif
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                      w_ready;
  logic                      w_busy;
  logic                      w_done;

  // Running frame state
  logic signed [SCORE_W-1:0] r_best;
  logic [IDX_W-1:0]          r_best_idx;
  logic [IDX_W-1:0]          r_cnt;

  // Published result registers
  logic [0:NUM_CLASSES-1]    r_class_oh;
  logic [IDX_W-1:0]          r_class_idx;
  logic signed [SCORE_W-1:0] r_max_score;
  logic                      r_frame_err;

  logic                      w_accept;
  logic                      w_first;
  logic                      w_acc;
  logic                      w_gt;
  logic                      w_full;
  logic                      w_end;
  logic                      w_err_end;
  logic signed [SCORE_W-1:0] w_best_next;
  logic [IDX_W-1:0]          w_idx_next;
  logic [0:NUM_CLASSES-1]    w_onehot;

  // Accept decision depends only on state so the handshake has no comb loop;
  // while reset is low every flop is held, so ungated acceptance is harmless.
  assign w_accept = score_valid && (r_state != S_DONE);
  assign w_first  = w_accept && (r_state == S_IDLE);
  assign w_acc    = w_accept && (r_state == S_ACCUM);
  assign w_gt     = score_data > r_best;
  assign w_full   = (r_cnt == c_LAST_IDX);

  // Frame end: last flag on any beat, or the NUM_CLASSES-th beat in ACCUM.
  // A first beat carrying last is always short (NUM_CLASSES >= 2); in ACCUM
  // the frame is well-formed only when last and the full count coincide.
  assign w_end     = w_first ? score_last : (w_acc && (score_last || w_full));
  assign w_err_end = w_first ? 1'b1 : (score_last ^ w_full);

  // Next best score / index including the beat presented this cycle
  always_comb begin
    w_best_next = r_best;
    w_idx_next  = r_best_idx;
    if (w_first) begin
      w_best_next = score_data;
      w_idx_next  = '0;
    end else if (w_acc && w_gt) begin
      w_best_next = score_data;
      w_idx_next  = r_cnt;
    end
  end

  // One-hot decode of the winning index
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      w_onehot[k] = (w_idx_next == IDX_W'(k));
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and handshake/status outputs
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_first) begin
          w_state_next = score_last ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_ready = 1'b1;
        w_busy  = 1'b1;
        if (w_end) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Running maximum and beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_best     <= '0;
      r_best_idx <= '0;
      r_cnt      <= '0;
    end else if (w_first) begin
      r_best     <= w_best_next;
      r_best_idx <= w_idx_next;
      r_cnt      <= IDX_W'(1);
    end else if (w_acc) begin
      r_best     <= w_best_next;
      r_best_idx <= w_idx_next;
      r_cnt      <= r_cnt + IDX_W'(1);
    end
  end

  // Result registers: load on the final beat so they are valid during DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_class_oh  <= '0;
      r_class_idx <= '0;
      r_max_score <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_end) begin
        r_class_oh  <= w_onehot;
        r_class_idx <= w_idx_next;
        r_max_score <= w_best_next;
        r_frame_err <= w_err_end;
      end else if (w_first) begin
        r_frame_err <= 1'b0;
      end
    end
  end

`ifdef NN_ARGMAX_MARGIN_EN
  logic signed [SCORE_W-1:0] r_second;
  logic                      r_has2;
  logic signed [SCORE_W-1:0] w_second_next;
  logic                      w_has2_next;
  logic [SCORE_W:0]          w_margin;
  logic                      w_low;
  logic [SCORE_W:0]          r_margin;
  logic                      r_low_conf;

  // Runner-up tracking: a new maximum demotes the old best; an equal-to-best
  // score always arrives at a higher index and so becomes runner-up.
  always_comb begin
    w_second_next = r_second;
    w_has2_next   = r_has2;
    if (w_first) begin
      w_second_next = '0;
      w_has2_next   = 1'b0;
    end else if (w_acc) begin
      if (w_gt) begin
        w_second_next = r_best;
        w_has2_next   = 1'b1;
      end else if (!r_has2 || (score_data > r_second) || (score_data == r_best)) begin
        w_second_next = score_data;
        w_has2_next   = 1'b1;
      end
    end
  end

  // Margin in SCORE_W+1 bits so the full signed span fits without overflow
  always_comb begin
    w_margin = '0;
    if (w_has2_next) begin
      w_margin = {w_best_next[SCORE_W-1], w_best_next}
               - {w_second_next[SCORE_W-1], w_second_next};
    end
    w_low = (w_margin <= (SCORE_W+1)'(MARGIN_THRESH));
  end

  // Runner-up state and registered confidence outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_second   <= '0;
      r_has2     <= 1'b0;
      r_margin   <= '0;
      r_low_conf <= 1'b0;
    end else begin
      if (w_first || w_acc) begin
        r_second <= w_second_next;
        r_has2   <= w_has2_next;
      end
      if (w_end) begin
        r_margin   <= w_margin;
        r_low_conf <= w_low;
      end
    end
  end

  assign margin   = r_margin;
  assign low_conf = r_low_conf;
`endif

  // Ready is forced low while reset is asserted
  assign score_ready    = w_ready && reset;
  assign busy           = w_busy;
  assign done           = w_done;
  assign classification = r_class_oh;
  assign class_idx      = r_class_idx;
  assign max_score      = r_max_score;
  assign frame_err      = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_nn_argmax_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nn_argmax_classifier
//  Description : Scoreboard bench for nn_argmax_classifier (10 classes,
//                16-bit scores). Define NN_ARGMAX_MARGIN_EN to also check the
//                margin / low_conf outputs with MARGIN_THRESH = 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_argmax_classifier;

  localparam int N = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          score_valid = 1'b0;
  logic          score_last = 1'b0;
  logic [15:0]   score_data = '0;
  logic          score_ready;
  logic [0:N-1]  classification;
  logic [3:0]    class_idx;
  logic [15:0]   max_score;
  logic          done;
  logic          busy;
  logic          frame_err;
`ifdef NN_ARGMAX_MARGIN_EN
  logic [16:0]   margin;
  logic          low_conf;
`endif

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;

  typedef struct {
    int          idx;
    logic [15:0] mx;
    bit          err;
    int          mg;
    bit          lc;
  } exp_t;

  exp_t sb[$];
  int   fr[N];

  nn_argmax_classifier #(
    .NUM_CLASSES(N),
    .SCORE_W(16)
`ifdef NN_ARGMAX_MARGIN_EN
    ,
    .MARGIN_THRESH(2)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .score_valid(score_valid),
    .score_ready(score_ready),
    .score_data(score_data),
    .score_last(score_last),
    .classification(classification),
    .class_idx(class_idx),
    .max_score(max_score),
    .done(done),
    .busy(busy),
    .frame_err(frame_err)
`ifdef NN_ARGMAX_MARGIN_EN
    ,
    .margin(margin),
    .low_conf(low_conf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input int idx, input int mx, input bit err, input int mg, input bit lc);
    exp_t e;
    e.idx = idx;
    e.mx  = 16'(mx);
    e.err = err;
    e.mg  = mg;
    e.lc  = lc;
    sb.push_back(e);
    exp_done++;
  endtask

  // Present one beat and hold it until accepted (bounded wait)
  task automatic beat(input int d, input bit l);
    int t;
    t = 0;
    score_valid = 1'b1;
    score_data  = 16'(d);
    score_last  = l;
    @(negedge clk);
    while (!score_ready && t < 50) begin
      t++;
      @(negedge clk);
    end
    if (!score_ready) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=ready_low required=ready_high at %0t", $time);
    end else begin
      @(posedge clk);
      #1;
    end
    score_valid = 1'b0;
    score_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit with_last, input int gap);
    int g;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) begin
        g = $urandom_range(gap, 0);
        repeat (g) begin
          @(posedge clk);
          #1;
        end
      end
      beat(fr[i], with_last && (i == n - 1));
    end
  endtask

  // Monitor: pop one expected result per done pulse
  always @(negedge clk) begin : mon
    exp_t         e;
    logic [0:N-1] oh;
    if (reset && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e  = sb.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        check("class_idx", 64'(class_idx), 64'(e.idx));
        check("classification", 64'(classification), 64'(oh));
        check("max_score", 64'(max_score), 64'(e.mx));
        check("frame_err", 64'(frame_err), 64'(e.err));
        check("ready_in_done", 64'(score_ready), 64'(0));
        check("busy_in_done", 64'(busy), 64'(1));
`ifdef NN_ARGMAX_MARGIN_EN
        check("margin", 64'(margin), 64'(e.mg));
        check("low_conf", 64'(low_conf), 64'(e.lc));
`endif
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(score_ready), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_classification"}, 64'(classification), 64'(0));
    check({tag, "_class_idx"}, 64'(class_idx), 64'(0));
    check({tag, "_max_score"}, 64'(max_score), 64'(0));
    check({tag, "_frame_err"}, 64'(frame_err), 64'(0));
`ifdef NN_ARGMAX_MARGIN_EN
    check({tag, "_margin"}, 64'(margin), 64'(0));
    check({tag, "_low_conf"}, 64'(low_conf), 64'(0));
`endif
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ready", 64'(score_ready), 64'(1));
    check("idle_classification", 64'(classification), 64'(0));

    // Basic frame
    fr = '{3, -5, 7, 2, 9, 1, 0, -8, 4, 6};
    push(4, 9, 0, 2, 1);
    send_frame(10, 1, 0);

    // Ties among negatives keep the lower index
    fr = '{-3, -3, -1, -3, -3, -3, -1, -3, -3, -3};
    push(2, -1, 0, 0, 1);
    send_frame(10, 1, 1);

    // Extreme values: most-negative at class 9 never wins
    fr = '{-32767, -32767, -32767, -32767, -32767, -32767, -32767, -32767, -32767, -32768};
    push(0, -32767, 0, 0, 1);
    send_frame(10, 1, 0);

    // Short frame: last on beat 4
    fr = '{1, 5, 2, 8, 0, 0, 0, 0, 0, 0};
    push(3, 8, 1, 3, 0);
    send_frame(4, 1, 2);

    // Missing last: frame closes on the 10th beat
    fr = '{5, 4, 3, 2, 1, 0, -1, -2, -3, 10};
    push(9, 10, 1, 5, 0);
    send_frame(10, 0, 0);

    // Good frame with random bubbles clears frame_err
    fr = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
    push(8, 9, 0, 1, 1);
    send_frame(10, 1, 3);

    // Back-to-back frames, valid held through DONE
    fr = '{-7, -7, -7, -7, -7, -7, -7, -7, -7, -7};
    push(0, -7, 0, 0, 1);
    send_frame(10, 1, 0);
    fr = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 99};
    push(9, 99, 0, 9, 0);
    send_frame(10, 1, 0);

    // Mid-frame reset after beat 5: no done, outputs cleared at once
    fr = '{50, 60, 70, 80, 90, 0, 0, 0, 0, 0};
    send_frame(5, 0, 0);
    reset = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Full frame after the aborted one
    fr = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, 0};
    push(9, 0, 0, 1, 1);
    send_frame(10, 1, 1);

    // Single-beat frame
    fr = '{42, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    push(0, 42, 1, 0, 1);
    send_frame(1, 1, 0);

    // Full signed span: margin uses all SCORE_W+1 bits
    fr = '{32767, -32768, 0, 0, 0, 0, 0, 0, 0, 0};
    push(0, 32767, 1, 65535, 0);
    send_frame(2, 1, 0);

    // Confidence frames: runner-up close vs far
    fr = '{8, 9, 1, 2, 3, 0, 0, 0, 0, 0};
    push(1, 9, 0, 1, 1);
    send_frame(10, 1, 0);
    fr = '{4, 9, 0, 1, 2, 3, 0, 0, 1, 2};
    push(1, 9, 0, 5, 0);
    send_frame(10, 1, 0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    check("done_count", 64'(done_cnt), 64'(exp_done));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
